// File: rtl/seq_det_ctrl.sv
// Serial pattern detector with run/window control.
// Compares the most recent cfg_len accepted bits against a programmable
// pattern. It counts matches per run and can stop a run after a fixed
// number of accepted bits.
// Ports:
//   clk, rst                 clock, async active-low reset
//   cfg_we/cfg_pattern/      configuration write; accepted only in IDLE
//   cfg_len/cfg_overlap
//   cfg_window               accepted-bit budget per run (0 = unlimited), sampled on start
//   start, stop              arm a run / abort to IDLE (stop wins)
//   in_valid, in_bit         qualified serial input
//   busy, done               registered RUN / DONE decodes
//   detected                 one-cycle match pulse
//   match_cnt                saturating match count for the current run
//   cfg_err                  sticky illegal-configuration flag
module seq_det_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_we,
  input  logic [7:0]  cfg_pattern,
  input  logic [3:0]  cfg_len,
  input  logic        cfg_overlap,
  input  logic [15:0] cfg_window,
  input  logic        start,
  input  logic        stop,
  input  logic        in_valid,
  input  logic        in_bit,
  output logic        busy,
  output logic        detected,
  output logic [7:0]  match_cnt,
  output logic        done,
  output logic        cfg_err
);

  localparam int unsigned PAT_W = 8;
  localparam int unsigned LEN_W = 4;
  localparam int unsigned WIN_W = 16;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [PAT_W-1:0]   pattern_q, pattern_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               overlap_q, overlap_d;
  logic [WIN_W-1:0]   window_q, window_d;
  logic [PAT_W-1:0]   hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic [WIN_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]   match_cnt_q, match_cnt_d;
  logic               detected_q, detected_d;
  logic               cfg_err_q, cfg_err_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [PAT_W-1:0]   hist_new;
  logic [LEN_W-1:0]   fill_new;
  logic [PAT_W-1:0]   len_mask;
  logic [WIN_W-1:0]   bit_cnt_inc;
  logic               is_match;
  logic               cfg_len_ok;

  // Match is judged on the history including the bit being accepted now.
  always_comb begin
    hist_new    = {hist_q[PAT_W-2:0], in_bit};
    fill_new    = (fill_q >= LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : fill_q + LEN_W'(1);
    len_mask    = PAT_W'((9'd1 << len_q) - 9'd1);
    is_match    = (fill_new >= len_q) && (((hist_new ^ pattern_q) & len_mask) == '0);
    bit_cnt_inc = bit_cnt_q + WIN_W'(1);
    cfg_len_ok  = (cfg_len != '0) && (cfg_len <= LEN_W'(PAT_W));
  end

  // Next-state and output logic.
  always_comb begin
    state_d     = state_q;
    pattern_d   = pattern_q;
    len_d       = len_q;
    overlap_d   = overlap_q;
    window_d    = window_q;
    hist_d      = hist_q;
    fill_d      = fill_q;
    bit_cnt_d   = bit_cnt_q;
    match_cnt_d = match_cnt_q;
    detected_d  = 1'b0;
    cfg_err_d   = cfg_err_q;

    // Configuration writes only land in IDLE with a legal length.
    if (cfg_we) begin
      if ((state_q == ST_IDLE) && cfg_len_ok) begin
        pattern_d = cfg_pattern;
        len_d     = cfg_len;
        overlap_d = cfg_overlap;
      end else begin
        cfg_err_d = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (start) begin
          state_d     = ST_RUN;
          hist_d      = '0;
          fill_d      = '0;
          bit_cnt_d   = '0;
          match_cnt_d = '0;
          cfg_err_d   = 1'b0;
          window_d    = cfg_window;
        end
      end
      ST_RUN: begin
        if (in_valid) begin
          hist_d    = hist_new;
          fill_d    = fill_new;
          bit_cnt_d = bit_cnt_inc;
          if (is_match) begin
            detected_d = 1'b1;
            if (match_cnt_q != '1) begin
              match_cnt_d = match_cnt_q + CNT_W'(1);
            end
            // Non-overlapping mode: matched bits may not seed the next match.
            if (!overlap_q) begin
              fill_d = '0;
            end
          end
        end
        if (stop) begin
          state_d = ST_IDLE;
        end else if (in_valid && (window_q != '0) && (bit_cnt_inc == window_q)) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      pattern_q   <= '0;
      len_q       <= LEN_W'(1);
      overlap_q   <= 1'b1;
      window_q    <= '0;
      hist_q      <= '0;
      fill_q      <= '0;
      bit_cnt_q   <= '0;
      match_cnt_q <= '0;
      detected_q  <= 1'b0;
      cfg_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pattern_q   <= pattern_d;
      len_q       <= len_d;
      overlap_q   <= overlap_d;
      window_q    <= window_d;
      hist_q      <= hist_d;
      fill_q      <= fill_d;
      bit_cnt_q   <= bit_cnt_d;
      match_cnt_q <= match_cnt_d;
      detected_q  <= detected_d;
      cfg_err_q   <= cfg_err_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign detected  = detected_q;
  assign match_cnt = match_cnt_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed self-checking bench for seq_det_ctrl.
module tb_seq_det_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic [7:0]  cfg_pattern;
  logic [3:0]  cfg_len;
  logic        cfg_overlap;
  logic [15:0] cfg_window;
  logic        start;
  logic        stop;
  logic        in_valid;
  logic        in_bit;
  logic        busy;
  logic        detected;
  logic [7:0]  match_cnt;
  logic        done;
  logic        cfg_err;

  int errors = 0;
  int checks = 0;
  logic [15:0] det;

  seq_det_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_we      (cfg_we),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .cfg_window  (cfg_window),
    .start       (start),
    .stop        (stop),
    .in_valid    (in_valid),
    .in_bit      (in_bit),
    .busy        (busy),
    .detected    (detected),
    .match_cnt   (match_cnt),
    .done        (done),
    .cfg_err     (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [7:0] p, input logic [3:0] l, input logic ov);
    cfg_we = 1'b1; cfg_pattern = p; cfg_len = l; cfg_overlap = ov;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic start_run(input logic [15:0] win);
    cfg_window = win; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic stop_run();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    in_valid = 1'b1; in_bit = b;
    tick();
    in_valid = 1'b0;
  endtask

  // Sends bits[n-1] first; result bit k-1 set if bit number k produced a pulse.
  task automatic send_seq(input logic [15:0] bits, input int n, output logic [15:0] d);
    d = '0;
    for (int i = n - 1; i >= 0; i--) begin
      in_valid = 1'b1; in_bit = bits[i];
      tick();
      if (detected === 1'b1) d[n-1-i] = 1'b1;
    end
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0; cfg_we = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
    cfg_window = '0; start = 1'b0; stop = 1'b0; in_valid = 1'b0; in_bit = 1'b0;

    // Reset state
    #12;
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_done", 16'(done), 16'd0);
    check("rst_det", 16'(detected), 16'd0);
    check("rst_cnt", 16'(match_cnt), 16'd0);
    check("rst_err", 16'(cfg_err), 16'd0);
    @(negedge clk);
    rst = 1'b1;

    // Reset configuration is pattern 0, len 1
    start_run(16'd0);
    check("run_busy", 16'(busy), 16'd1);
    send_bit(1'b0);
    check("defcfg_det0", 16'(detected), 16'd1);
    send_bit(1'b1);
    check("defcfg_det1", 16'(detected), 16'd0);
    stop_run();
    check("defcfg_stop_busy", 16'(busy), 16'd0);
    check("defcfg_cnt_held", 16'(match_cnt), 16'd1);

    // 110011 len 6 overlapping
    cfg(8'b0011_0011, 4'd6, 1'b1);
    start_run(16'd0);
    check("p6_cnt_clr", 16'(match_cnt), 16'd0);
    send_seq(16'b11_0011_0011, 10, det);
    check("p6_det_pos", det, 16'h0220);
    check("p6_cnt", 16'(match_cnt), 16'd2);
    tick();
    check("p6_pulse_one", 16'(detected), 16'd0);
    stop_run();

    // 1010 overlapping vs non-overlapping
    cfg(8'b0000_1010, 4'd4, 1'b1);
    start_run(16'd0);
    send_seq(16'b101_0101, 7, det);
    check("ov1_det_pos", det, 16'h0028);
    check("ov1_cnt", 16'(match_cnt), 16'd2);
    stop_run();
    cfg(8'b0000_1010, 4'd4, 1'b0);
    start_run(16'd0);
    send_seq(16'b101_0101, 7, det);
    check("ov0_det_pos", det, 16'h0008);
    check("ov0_cnt", 16'(match_cnt), 16'd1);
    stop_run();

    // Window 5, pattern 1, gaps between bits
    cfg(8'h01, 4'd1, 1'b1);
    start_run(16'd5);
    for (int i = 0; i < 4; i++) begin
      send_bit(1'b1);
      tick();
    end
    check("win_busy4", 16'(busy), 16'd1);
    check("win_done4", 16'(done), 16'd0);
    send_bit(1'b1);
    check("win_det5", 16'(detected), 16'd1);
    check("win_cnt5", 16'(match_cnt), 16'd5);
    check("win_done5", 16'(done), 16'd1);
    check("win_busy5", 16'(busy), 16'd0);
    send_bit(1'b1);
    check("done_ign_det", 16'(detected), 16'd0);
    check("done_ign_cnt", 16'(match_cnt), 16'd5);
    start_run(16'd0);
    check("rerun_busy", 16'(busy), 16'd1);
    check("rerun_done", 16'(done), 16'd0);
    check("rerun_cnt", 16'(match_cnt), 16'd0);
    stop_run();

    // start together with stop in IDLE: stop wins
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    check("startstop_busy", 16'(busy), 16'd0);

    // Illegal configuration writes
    cfg(8'h00, 4'd9, 1'b0);
    check("len9_err", 16'(cfg_err), 16'd1);
    start_run(16'd0);
    check("start_clr_err", 16'(cfg_err), 16'd0);
    cfg(8'h00, 4'd1, 1'b1);
    check("run_cfg_err", 16'(cfg_err), 16'd1);
    send_bit(1'b1);
    check("cfg_kept_det1", 16'(detected), 16'd1);
    send_bit(1'b0);
    check("cfg_kept_det0", 16'(detected), 16'd0);
    stop_run();

    // Saturation at 255
    start_run(16'd0);
    for (int i = 0; i < 300; i++) send_bit(1'b1);
    check("sat_cnt", 16'(match_cnt), 16'd255);
    stop_run();
    check("sat_stop_busy", 16'(busy), 16'd0);
    check("sat_stop_cnt", 16'(match_cnt), 16'd255);

    // Reset mid-pattern
    cfg(8'b0011_0011, 4'd6, 1'b1);
    start_run(16'd0);
    cfg(8'h00, 4'd1, 1'b1);
    check("mid_err_set", 16'(cfg_err), 16'd1);
    send_seq(16'b110, 3, det);
    check("mid_no_det", det, 16'h0000);
    rst = 1'b0;
    #1;
    check("mid_rst_busy", 16'(busy), 16'd0);
    check("mid_rst_cnt", 16'(match_cnt), 16'd0);
    check("mid_rst_err", 16'(cfg_err), 16'd0);
    check("mid_rst_det", 16'(detected), 16'd0);
    @(negedge clk);
    rst = 1'b1;
    cfg(8'b0011_0011, 4'd6, 1'b1);
    start_run(16'd0);
    send_seq(16'b11_0011, 6, det);
    check("post_rst_det", det, 16'h0020);
    check("post_rst_cnt", 16'(match_cnt), 16'd1);
    stop_run();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_det_ctrl.md
SEQ_DET_CTRL -- requirements
Module: seq_det_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low (rst=0 resets).
REQ-003 SHALL have port cfg_we, input, 1 bit: writes cfg_pattern, cfg_len and cfg_overlap (accepted only in IDLE).
REQ-004 SHALL have port cfg_pattern, input, 8 bits: target pattern; bit [cfg_len-1] is the first serial bit and bit 0 the last.
REQ-005 SHALL have port cfg_len, input, 4 bits: pattern length, legal range 1..8.
REQ-006 SHALL have port cfg_overlap, input, 1 bit: 1 = overlapping matches allowed; 0 = history clears after each match.
REQ-007 SHALL have port cfg_window, input, 16 bits: number of accepted bits per run; 0 = unlimited; sampled on start.
REQ-008 SHALL have port start, input, 1 bit: arms a run (honoured only in IDLE or DONE).
REQ-009 SHALL have port stop, input, 1 bit: aborts a run to IDLE.
REQ-010 SHALL have port in_valid, input, 1 bit: qualifies in_bit.
REQ-011 SHALL have port in_bit, input, 1 bit: serial data bit.
REQ-012 SHALL have port busy, output, 1 bit: high in RUN.
REQ-013 SHALL have port detected, output, 1 bit: registered one-cycle match pulse.
REQ-014 SHALL have port match_cnt, output, 8 bits: matches in the current run, saturating.
REQ-015 SHALL have port done, output, 1 bit: high in DONE.
REQ-016 SHALL have port cfg_err, output, 1 bit: sticky flag for an illegal configuration write.

Function
REQ-017 SHALL implement states IDLE, RUN and DONE.
REQ-018 In IDLE, cfg_we with cfg_len in 1..8 SHALL latch the pattern, length and overlap fields; cfg_len 0 or >8 SHALL leave the configuration unchanged and set cfg_err.
REQ-019 cfg_we outside IDLE SHALL be ignored and SHALL set cfg_err.
REQ-020 start in IDLE or DONE SHALL go to RUN the next cycle, and SHALL clear history, fill count, match_cnt, bit counter and cfg_err and latch cfg_window.
REQ-021 In RUN, each cycle with in_valid=1 SHALL shift in_bit into an 8-bit history (LSB = newest), increment the fill count (saturating at 8) and increment the bit counter.
REQ-022 A match SHALL occur when fill count >= len and history[len-1:0] == pattern[len-1:0], both evaluated including the bit just shifted in.
REQ-023 On a match, detected SHALL be 1 in the cycle after the accepting edge, for exactly one cycle; match_cnt SHALL increment, saturating at 255.
REQ-024 On a match with cfg_overlap=0, the fill count SHALL reset to 0 so the matching bits are not reused.
REQ-025 With cfg_window != 0, the edge that accepts bit number cfg_window SHALL move the FSM to DONE; a match on that bit SHALL still be counted and pulsed.
REQ-026 stop in RUN SHALL go to IDLE next cycle; match_cnt SHALL hold its value; a match on the same edge SHALL still be counted.
REQ-027 If start and stop are asserted together, stop SHALL win.
REQ-028 DONE SHALL hold match_cnt until start (re-run) or stop (to IDLE); in_valid SHALL be ignored in IDLE and DONE.
REQ-029 The bit counter SHALL be 16 bits; with cfg_window=0 it SHALL wrap without effect.
REQ-030 busy and done SHALL be registered state decodes with no combinational path from inputs.

Reset
REQ-031 rst=0 SHALL immediately force IDLE with busy=0, done=0, detected=0, match_cnt=0, cfg_err=0, history and counters 0, pattern=8'h00, len=1, overlap=1.
REQ-032 Reset asserted mid-run SHALL abandon the run with no detected pulse; the first start after release SHALL behave as a fresh run.

Verification
REQ-033 Config 110011/len 6/overlap 1, window 0, stream 1100110011 -> detected after bits 6 and 10; match_cnt=2.
REQ-034 Config 1010/len 4, stream 1010101: overlap=1 -> match_cnt=2 (bits 4 and 6); overlap=0 -> match_cnt=1 (bit 4).
REQ-035 Window 5, pattern 1/len 1, stream 11111 with in_valid gaps -> match_cnt=5, done=1 after the 5th accepted bit, busy=0.
REQ-036 cfg_we with len=9 in IDLE, then cfg_we during RUN -> cfg_err=1 both times and the configuration stays unchanged.
REQ-037 Pattern 1/len 1, 300 ones with window 0 -> match_cnt saturates at 255; stop -> IDLE with 255 held.
REQ-038 Drive rst=0 mid-pattern (after 3 of 6 bits), release, start, send 110011 -> exactly one detection.
